// File: rtl/fp_mul_pkg.sv
// rtl/fp_mul_pkg.sv - shared constants and types for the FP32 multiply back end
package fp_mul_pkg;

    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 23;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        INF  = 2'd1,
        NAN  = 2'd2,
        NORM = 2'd3
    } fp_class_e;

    typedef struct packed {
        logic ovf;
        logic unf;
        logic inv;
    } fp_flags_t;

endpackage

// File: rtl/fp_classify.sv
// rtl/fp_classify.sv - combinational FP32 operand classifier (denormals read as zero)
module fp_classify
    import fp_mul_pkg::*;
(
    input  logic [31:0] op,
    output fp_class_e   cls
);

    logic [EXP_W-1:0]  exp_f;
    logic [FRAC_W-1:0] frac_f;

    assign exp_f  = op[30:23];
    assign frac_f = op[22:0];

    always_comb begin
        cls = NORM;
        if (exp_f == '0) begin
            cls = ZERO;
        end else if (exp_f == '1) begin
            cls = (frac_f != '0) ? NAN : INF;
        end
    end

endmodule

// File: rtl/fp_mul_normalize_pack.sv
// rtl/fp_mul_normalize_pack.sv - FP32 product exponent, special-case resolution and packing
module fp_mul_normalize_pack
    import fp_mul_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_op_a,
    input  logic [31:0] in_op_b,
    input  logic [22:0] in_frac,
    input  logic        in_norm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_ovf,
    output logic        out_unf,
    output logic        out_inv
);

    fp_class_e         a_cls;
    fp_class_e         b_cls;
    logic [9:0]        e_sum;

    logic              s1_v;
    logic              s1_sign;
    logic signed [9:0] s1_e;
    logic [22:0]       s1_frac;
    fp_class_e         s1_ca;
    fp_class_e         s1_cb;
    logic              s1_adv;

    logic              s2_v;
    fp_flags_t         s2_flags;

    logic [31:0]       pack_res;
    fp_flags_t         pack_flags;
    logic              any_nan;
    logic              any_inf;
    logic              any_zero;
    logic              inf_zero;

    fp_classify u_class_a (.op(in_op_a), .cls(a_cls));
    fp_classify u_class_b (.op(in_op_b), .cls(b_cls));

    // Wraps harmlessly for ZERO/INF/NAN operands; those never reach rule 6.
    assign e_sum = 10'(in_op_a[30:23]) + 10'(in_op_b[30:23]) + 10'(in_norm) - 10'(BIAS);

    assign s1_adv   = !s2_v || out_ready;
    assign in_ready = !s1_v || s1_adv;

    assign any_nan  = (s1_ca == NAN) || (s1_cb == NAN);
    assign any_inf  = (s1_ca == INF) || (s1_cb == INF);
    assign any_zero = (s1_ca == ZERO) || (s1_cb == ZERO);
    assign inf_zero = ((s1_ca == INF) && (s1_cb == ZERO)) || ((s1_ca == ZERO) && (s1_cb == INF));

    always_comb begin
        pack_res   = {s1_sign, s1_e[7:0], s1_frac};
        pack_flags = '0;
        if (any_nan || inf_zero) begin
            pack_res       = QNAN;
            pack_flags.inv = 1'b1;
        end else if (any_inf) begin
            pack_res = {s1_sign, 8'hFF, 23'h0};
        end else if (any_zero) begin
            pack_res = {s1_sign, 31'h0};
        end else if (s1_e >= $signed(10'(EXP_MAX))) begin
            pack_res       = {s1_sign, 8'hFF, 23'h0};
            pack_flags.ovf = 1'b1;
        end else if (s1_e <= $signed(10'd0)) begin
            pack_res       = {s1_sign, 31'h0};
            pack_flags.unf = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v       <= 1'b0;
            s1_sign    <= 1'b0;
            s1_e       <= '0;
            s1_frac    <= '0;
            s1_ca      <= ZERO;
            s1_cb      <= ZERO;
            s2_v       <= 1'b0;
            out_result <= '0;
            s2_flags   <= '0;
        end else begin
            if (in_ready) begin
                s1_v <= in_valid;
            end
            if (in_valid && in_ready) begin
                s1_sign <= in_op_a[31] ^ in_op_b[31];
                s1_e    <= $signed(e_sum);
                s1_frac <= in_frac;
                s1_ca   <= a_cls;
                s1_cb   <= b_cls;
            end
            if (s1_adv) begin
                s2_v <= s1_v;
            end
            if (s1_v && s1_adv) begin
                out_result <= pack_res;
                s2_flags   <= pack_flags;
            end
        end
    end

    assign out_valid = s2_v;
    assign out_ovf   = s2_flags.ovf;
    assign out_unf   = s2_flags.unf;
    assign out_inv   = s2_flags.inv;

endmodule

// File: tb/tb_fp_mul_normalize_pack.sv
// tb/tb_fp_mul_normalize_pack.sv - randomized scoreboard bench for fp_mul_normalize_pack
module tb_fp_mul_normalize_pack;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_op_a;
    logic [31:0] in_op_b;
    logic [22:0] in_frac;
    logic        in_norm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_ovf;
    logic        out_unf;
    logic        out_inv;

    logic [34:0] dut_out;
    logic [34:0] sb[$];
    logic        held;
    logic [34:0] held_val;
    int          n_checks = 0;
    int          n_fail   = 0;

    fp_mul_normalize_pack dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op_a(in_op_a), .in_op_b(in_op_b), .in_frac(in_frac), .in_norm(in_norm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_ovf(out_ovf), .out_unf(out_unf), .out_inv(out_inv)
    );

    always #5 clk = ~clk;

    assign dut_out = {out_ovf, out_unf, out_inv, out_result};

    task automatic check(input string name, input logic [35:0] got, input logic [35:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: {ovf, unf, inv, result} straight from the IEEE field values.
    function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [22:0] frac, input logic norm);
        int ea, eb, e;
        bit s, na, nb, ia, ib, za, zb;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        e  = ea + eb + int'(norm) - 127;
        s  = a[31] ^ b[31];
        na = (ea == 255) && (a[22:0] != 0);
        nb = (eb == 255) && (b[22:0] != 0);
        ia = (ea == 255) && (a[22:0] == 0);
        ib = (eb == 255) && (b[22:0] == 0);
        za = (ea == 0);
        zb = (eb == 0);
        if (na || nb || (ia && zb) || (ib && za)) return {3'b001, 32'h7FC00000};
        if (ia || ib) return {3'b000, s, 8'hFF, 23'h0};
        if (za || zb) return {3'b000, s, 31'h0};
        if (e >= 255) return {3'b100, s, 8'hFF, 23'h0};
        if (e <= 0)   return {3'b010, s, 31'h0};
        return {3'b000, s, 8'(e), frac};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] r;
        int k;
        r = $urandom;
        k = int'($urandom_range(0, 15));
        case (k)
            0:       r[30:23] = 8'h00;
            1:       begin r[30:23] = 8'hFF; r[22:0] = 23'h0; end
            2:       begin r[30:23] = 8'hFF; r[0] = 1'b1; end
            3, 4:    r[30:23] = 8'($urandom_range(200, 254));
            5, 6:    r[30:23] = 8'($urandom_range(1, 60));
            default: r[30:23] = 8'($urandom_range(90, 165));
        endcase
        return r;
    endfunction

    // Fraction and normalize flag come from a true 24x24 mantissa product.
    task automatic gen_beat();
        logic [47:0] ma, mb, p;
        in_op_a = rand_op();
        in_op_b = rand_op();
        ma = {24'h0, 1'b1, in_op_a[22:0]};
        mb = {24'h0, 1'b1, in_op_b[22:0]};
        p  = ma * mb;
        in_norm = p[47];
        in_frac = p[47] ? p[46:24] : p[45:23];
    endtask

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            held = 1'b0;
        end else begin
            if (in_valid && in_ready) sb.push_back(model(in_op_a, in_op_b, in_frac, in_norm));
            if (held) check("hold_stable", {out_valid, dut_out}, {1'b1, held_val});
            if (out_valid && out_ready) begin
                if (sb.size() == 0) check("unexpected_beat", {1'b0, dut_out}, 36'h0);
                else check("scoreboard", {1'b0, dut_out}, {1'b0, sb.pop_front()});
            end
            held     = out_valid && !out_ready;
            held_val = dut_out;
        end
    end

    task automatic directed(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic [22:0] f, input logic n, input logic [34:0] exp);
        check({name, "_model"}, {1'b0, model(a, b, f, n)}, {1'b0, exp});
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_op_a = a; in_op_b = b; in_frac = f; in_norm = n;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check({name, "_dut"}, {out_valid, dut_out}, {1'b1, exp});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_op_a = '0; in_op_b = '0; in_frac = '0; in_norm = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("reset_state", {out_valid, dut_out}, 36'h0);
        check("reset_in_ready", {35'h0, in_ready}, 36'h1);

        directed("nominal",   32'h3FC3D70A, 32'h3FE147AE, 23'h2C56D6, 1'b1, {3'b000, 32'h402C56D6});
        directed("ovf_pos",   32'h7F000000, 32'h40000000, 23'h0, 1'b0, {3'b100, 32'h7F800000});
        directed("ovf_neg",   32'hFF000000, 32'h40000000, 23'h0, 1'b0, {3'b100, 32'hFF800000});
        directed("ovf_norm",  32'h7F000000, 32'h3F800000, 23'h0, 1'b1, {3'b100, 32'h7F800000});
        directed("e_254",     32'h7F000000, 32'h3F800000, 23'h0, 1'b0, {3'b000, 32'h7F000000});
        directed("e_1",       32'h00800000, 32'h3F800000, 23'h0, 1'b0, {3'b000, 32'h00800000});
        directed("unf_pos",   32'h00800000, 32'h3F000000, 23'h0, 1'b0, {3'b010, 32'h00000000});
        directed("unf_neg",   32'h80800000, 32'h3F000000, 23'h0, 1'b0, {3'b010, 32'h80000000});
        directed("inf_zero",  32'h7F800000, 32'h00000000, 23'h0, 1'b0, {3'b001, 32'h7FC00000});
        directed("snan",      32'h7FA00000, 32'h3F800000, 23'h0, 1'b0, {3'b001, 32'h7FC00000});
        directed("nan_sign",  32'hFFA00000, 32'hBF800000, 23'h0, 1'b0, {3'b001, 32'h7FC00000});
        directed("neg_inf",   32'hFF800000, 32'h40000000, 23'h0, 1'b0, {3'b000, 32'hFF800000});
        directed("denormal",  32'h00000001, 32'h3F800000, 23'h0, 1'b0, {3'b000, 32'h00000000});

        // Backpressure: three beats against a stalled consumer.
        @(posedge clk); #1;
        out_ready = 1'b0; gen_beat(); in_valid = 1'b1;
        @(posedge clk); #1;
        gen_beat();
        @(posedge clk); #1;
        gen_beat();
        check("bp_in_ready_low", {35'h0, in_ready}, 36'h0);
        repeat (3) @(posedge clk);
        #1;
        check("bp_in_ready_held", {35'h0, in_ready}, 36'h0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("bp_drained", {4'h0, sb.size()}, 36'h0);

        for (int i = 0; i < 8; i++) begin
            gen_beat(); in_valid = 1'b1;
            check("throughput_in_ready", {35'h0, in_ready}, 36'h1);
            if (i >= 2) check("throughput_out_valid", {35'h0, out_valid}, 36'h1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset with both stages occupied.
        out_ready = 1'b0; gen_beat(); in_valid = 1'b1;
        @(posedge clk); #1;
        gen_beat();
        @(posedge clk); #1;
        in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_outputs", {out_valid, dut_out}, 36'h0);
        check("rst_mid_in_ready", {35'h0, in_ready}, 36'h1);
        directed("post_reset", 32'h3FC3D70A, 32'h3FE147AE, 23'h2C56D6, 1'b1, {3'b000, 32'h402C56D6});

        begin
            bit took;
            for (int c = 0; c < 3000; c++) begin
                @(negedge clk);
                took = in_valid && in_ready;
                @(posedge clk); #1;
                out_ready = ($urandom_range(0, 9) < 7);
                if (took || !in_valid) begin
                    if ($urandom_range(0, 3) != 0) begin
                        gen_beat();
                        in_valid = 1'b1;
                    end else begin
                        in_valid = 1'b0;
                    end
                end
            end
        end

        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 50 && (sb.size() != 0 || out_valid); c++) @(posedge clk);
        #1;
        check("final_drain", {3'h0, out_valid, sb.size()}, 36'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
